// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue path: operand word format, operand pair, issue FSM states.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    fp_word_t op_a;
    fp_word_t op_b;
  } fp_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

  // Biased exponent field of an operand word (sign bit sits above it).
  function automatic logic [EXP_W-1:0] fp_exponent(input fp_word_t w);
    return w[MAN_W +: EXP_W];
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and FPU-side buses of the issue controller; master is the environment, slave the controller.
interface fpu_issue_ctrl_if #(
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 4,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_op_a;
  logic [DATA_W-1:0]   in_op_b;

  logic [DATA_W-1:0]   fpu_op_a;
  logic [DATA_W-1:0]   fpu_op_b;
  logic                fpu_restart_n;
  logic [DATA_W-1:0]   fpu_data;
  logic [STATUS_W-1:0] fpu_status;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [STATUS_W-1:0] out_status;

  logic                busy;
  logic [CNT_W-1:0]    fifo_count;

  modport master (
    output in_valid, in_op_a, in_op_b, fpu_data, fpu_status, out_ready,
    input  in_ready, fpu_op_a, fpu_op_b, fpu_restart_n,
           out_valid, out_data, out_status, busy, fifo_count
  );

  modport slave (
    input  in_valid, in_op_a, in_op_b, fpu_data, fpu_status, out_ready,
    output in_ready, fpu_op_a, fpu_op_b, fpu_restart_n,
           out_valid, out_data, out_status, busy, fifo_count
  );

endinterface

// File: rtl/fpu_operand_fifo.sv
// Count-based synchronous FIFO of operand pairs; head is visible combinationally on rdata_o.
module fpu_operand_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  fp_pair_t      wdata_i,
  input  logic          pop_i,
  output fp_pair_t      rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fp_pair_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guarded pointer/occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset flushes the queue by clearing pointers and count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller: queues operand pairs, sequences FPU restart + latency wait, captures results.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FPU_LATENCY = 8,
  parameter int DATA_W      = 32,
  parameter int STATUS_W    = 4
) (
  input logic              clock,
  input logic              reset,
  fpu_issue_ctrl_if.slave  bus
);

  localparam int CNT_W  = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  issue_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  fp_word_t            op_a_q, op_a_d;
  fp_word_t            op_b_q, op_b_d;
  logic                restart_n_q, restart_n_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [STATUS_W-1:0] out_status_q, out_status_d;

  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  fp_pair_t            fifo_wdata, fifo_head;

  // Acceptance depends only on registered occupancy, so a same-cycle pop never opens the input.
  assign bus.in_ready     = !reset && !fifo_full;
  assign fifo_push        = bus.in_valid && bus.in_ready;
  assign fifo_wdata.op_a  = bus.in_op_a;
  assign fifo_wdata.op_b  = bus.in_op_b;

  fpu_operand_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state logic: pop in IDLE, one-cycle restart in ISSUE, count latency in WAIT, hand off in HOLD.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_a_d   = fifo_head.op_a;
          op_b_d   = fifo_head.op_b;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(FPU_LATENCY - 1)) begin
          out_data_d   = bus.fpu_data;
          out_status_d = bus.fpu_status;
          out_valid_d  = 1'b1;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Restart is registered so it is low exactly for the cycle the FSM sits in ISSUE.
    restart_n_d = (state_d != ISSUE);
  end

  // State and output registers; reset abandons any in-flight operation and holds the FPU in restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      restart_n_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      restart_n_q  <= restart_n_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
    end
  end

  assign bus.fpu_op_a      = op_a_q;
  assign bus.fpu_op_b      = op_b_q;
  assign bus.fpu_restart_n = restart_n_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_status    = out_status_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.fifo_count    = fifo_count;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a table-driven behavioural FPU stub.
module tb_fpu_issue_ctrl;

  localparam int L = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_issue_ctrl_if #(.DATA_W(32), .STATUS_W(4), .FIFO_DEPTH(4)) bus ();

  fpu_issue_ctrl #(
    .FIFO_DEPTH(4), .FPU_LATENCY(L), .DATA_W(32), .STATUS_W(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Operand pairs with hand-computed sums (1 sign, 6 exp bias 31, 25 mantissa) and stub status.
  localparam logic [31:0] PA [8] = '{32'hBE000000, 32'h40000000, 32'h3E000000, 32'h40000000,
                                     32'hC0000000, 32'h42000000, 32'h3E000000, 32'h3E000000};
  localparam logic [31:0] PB [8] = '{32'hBE000000, 32'hC2000000, 32'h3E000000, 32'h40000000,
                                     32'hC0000000, 32'hBE000000, 32'h00000000, 32'hBE000000};
  localparam logic [31:0] PR [8] = '{32'hC0000000, 32'hC0000000, 32'h40000000, 32'h42000000,
                                     32'hC2000000, 32'h41000000, 32'h3E000000, 32'h00000000};
  localparam logic [3:0]  PS [8] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1};

  // FPU stub: result is only correct during the single cycle L cycles after restart release.
  logic [7:0]  mcnt = 8'hFF;
  logic [31:0] m_a = '0, m_b = '0;
  logic [31:0] m_r;
  logic [3:0]  m_s;

  always @(posedge clock) begin
    if (!bus.fpu_restart_n) begin
      m_a  <= bus.fpu_op_a;
      m_b  <= bus.fpu_op_b;
      mcnt <= 8'd0;
    end else if (mcnt != 8'hFF) begin
      mcnt <= mcnt + 8'd1;
    end
  end

  always_comb begin
    m_r = 32'h0BADF00D;
    m_s = 4'hE;
    for (int k = 0; k < 8; k++)
      if (m_a == PA[k] && m_b == PB[k]) begin
        m_r = PR[k];
        m_s = PS[k];
      end
  end

  assign bus.fpu_data   = (mcnt == 8'(L - 1)) ? m_r : 32'hDEADBEEF;
  assign bus.fpu_status = (mcnt == 8'(L - 1)) ? m_s : 4'hF;

  // Result collector and restart-pulse counter.
  logic [35:0] got_q [$];
  int issue_cnt = 0;
  int pulse_err = 0;
  logic prev_issue = 1'b0;

  always @(posedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_data, bus.out_status});
    if (!reset && bus.busy && !bus.fpu_restart_n) begin
      issue_cnt <= issue_cnt + 1;
      if (prev_issue) pulse_err <= pulse_err + 1;
      prev_issue <= 1'b1;
    end else begin
      prev_issue <= 1'b0;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Push pairs first..last back-to-back, holding in_valid and advancing on acceptance.
  task automatic push_range(input int first, input int last);
    int idx;
    logic rdy;
    idx = first;
    bus.in_valid = 1'b1;
    bus.in_op_a  = PA[idx];
    bus.in_op_b  = PB[idx];
    for (int c = 0; c < 200 && idx <= last; c++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) begin
        idx++;
        if (idx <= last) begin
          bus.in_op_a = PA[idx];
          bus.in_op_b = PB[idx];
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op_a = 32'h12345678;
    bus.in_op_b = 32'h9ABCDEF0;
    bus.out_ready = 1'b0;
    step(); step(); step();
    vectors++; if (bus.fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.fpu_restart_n !== 1'b0) begin miscompares++; $display("FAIL reset_restart_n got %b want 0", bus.fpu_restart_n); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if ({bus.fpu_op_a, bus.fpu_op_b, bus.out_data, bus.out_status} !== 100'd0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h %h want 0", bus.fpu_op_a, bus.fpu_op_b, bus.out_data, bus.out_status); end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();
    vectors++; if (bus.fpu_restart_n !== 1'b1) begin miscompares++; $display("FAIL idle_restart_n got %b want 1", bus.fpu_restart_n); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int bad;
    bad = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op_a = PA[0];
    bus.in_op_b = PB[0];
    step();                                   // cycle a+1
    bus.in_valid = 1'b0;
    vectors++; if (bus.fifo_count !== 3'd1 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL single_a1 got count=%0d busy=%b want 1/0", bus.fifo_count, bus.busy); end
    step();                                   // cycle a+2: ISSUE
    vectors++; if (bus.fpu_restart_n !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL single_issue got restart_n=%b busy=%b want 0/1", bus.fpu_restart_n, bus.busy); end
    vectors++; if (bus.fpu_op_a !== 32'hBE000000 || bus.fpu_op_b !== 32'hBE000000) begin
      miscompares++; $display("FAIL single_ops got %h %h want BE000000 BE000000", bus.fpu_op_a, bus.fpu_op_b); end
    for (int i = 0; i < L; i++) begin         // cycles a+3 .. a+10
      step();
      if (bus.fpu_restart_n !== 1'b1 || bus.out_valid !== 1'b0 || bus.fpu_op_a !== 32'hBE000000) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_wait got %0d bad cycles want 0", bad); end
    step();                                   // cycle a+11
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_a11 got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'hC0000000 || bus.out_status !== 4'h0) begin
      miscompares++; $display("FAIL single_result got %h/%h want C0000000/0", bus.out_data, bus.out_status); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL single_release got valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_back_to_back();
    int idx, bad;
    logic rdy, saw_full;
    bad = 0;
    saw_full = 1'b0;
    got_q.delete();
    bus.out_ready = 1'b1;
    idx = 1;
    bus.in_valid = 1'b1;
    bus.in_op_a = PA[1];
    bus.in_op_b = PB[1];
    for (int c = 0; c < 200 && idx <= 6; c++) begin
      rdy = bus.in_ready;
      if (bus.fifo_count == 3'd4) saw_full = 1'b1;
      if (rdy !== (bus.fifo_count != 3'd4)) bad++;
      step();
      if (rdy) begin
        idx++;
        if (idx <= 6) begin
          bus.in_op_a = PA[idx];
          bus.in_op_b = PB[idx];
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++; if (saw_full !== 1'b1 || bad !== 0) begin
      miscompares++; $display("FAIL stream_in_ready got full_seen=%b bad=%0d want 1/0", saw_full, bad); end
    for (int i = 0; i < 200 && got_q.size() < 6; i++) step();
    repeat (30) step();
    vectors++; if (got_q.size() !== 6) begin miscompares++; $display("FAIL stream_count got %0d want 6", got_q.size()); end
    for (int k = 0; k < 6; k++) begin
      logic [35:0] g;
      g = (k < got_q.size()) ? got_q[k] : 36'hx;
      vectors++; if (g !== {PR[k+1], PS[k+1]}) begin
        miscompares++; $display("FAIL stream_result%0d got %h want %h", k, g, {PR[k+1], PS[k+1]}); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    logic [31:0] d0;
    logic [3:0]  s0;
    int i0, bad;
    bad = 0;
    do_reset();
    got_q.delete();
    bus.out_ready = 1'b0;
    push_range(1, 5);
    bus.in_valid = 1'b1;
    bus.in_op_a = PA[6];
    bus.in_op_b = PB[6];
    for (int i = 0; i < 30 && !bus.out_valid; i++) step();
    d0 = bus.out_data;
    s0 = bus.out_status;
    i0 = issue_cnt;
    vectors++; if (d0 !== PR[1] || s0 !== PS[1]) begin
      miscompares++; $display("FAIL hold_first got %h/%h want %h/%h", d0, s0, PR[1], PS[1]); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.out_status !== s0 ||
          bus.in_ready !== 1'b0 || bus.fpu_restart_n !== 1'b1) bad++;
    end
    vectors++; if (bad !== 0 || issue_cnt !== i0) begin
      miscompares++; $display("FAIL hold_stable got bad=%0d issues=%0d want 0/%0d", bad, issue_cnt, i0); end
    vectors++; if (bus.fifo_count !== 3'd4) begin miscompares++; $display("FAIL hold_full got %0d want 4", bus.fifo_count); end
    bus.out_ready = 1'b1;
    step();                                   // h+1: IDLE, pop cycle
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
      miscompares++; $display("FAIL pop_cycle got valid=%b in_ready=%b count=%0d want 0/0/4", bus.out_valid, bus.in_ready, bus.fifo_count); end
    step();                                   // h+2: ISSUE, input opens
    vectors++; if (bus.fpu_restart_n !== 1'b0 || bus.in_ready !== 1'b1 || bus.fifo_count !== 3'd3) begin
      miscompares++; $display("FAIL after_pop got restart_n=%b in_ready=%b count=%0d want 0/1/3", bus.fpu_restart_n, bus.in_ready, bus.fifo_count); end
    step();                                   // h+3
    bus.in_valid = 1'b0;
    vectors++; if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL one_accept got count=%0d in_ready=%b want 4/0", bus.fifo_count, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 6; i++) step();
    repeat (30) step();
    vectors++; if (got_q.size() !== 6) begin miscompares++; $display("FAIL hold_total got %0d want 6", got_q.size()); end
    for (int k = 0; k < 6; k++) begin
      logic [35:0] g;
      g = (k < got_q.size()) ? got_q[k] : 36'hx;
      vectors++; if (g !== {PR[k+1], PS[k+1]}) begin
        miscompares++; $display("FAIL hold_order%0d got %h want %h", k, g, {PR[k+1], PS[k+1]}); end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_status_capture();
    bus.out_ready = 1'b0;
    push_range(7, 7);
    for (int i = 0; i < 30 && !bus.out_valid; i++) step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000000 || bus.out_status !== 4'b0001) begin
      miscompares++; $display("FAIL capture got %b %h/%h want 1 00000000/1", bus.out_valid, bus.out_data, bus.out_status); end
    repeat (5) step();
    vectors++; if (bus.fpu_status !== 4'hF || bus.out_status !== 4'b0001 || bus.out_data !== 32'h0) begin
      miscompares++; $display("FAIL capture_hold got fpu=%h out=%h/%h want F 1/00000000", bus.fpu_status, bus.out_status, bus.out_data); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL capture_release got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midop();
    got_q.delete();
    bus.out_ready = 1'b1;
    push_range(1, 4);
    vectors++; if (bus.fifo_count !== 3'd3 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midop_pre got count=%0d busy=%b valid=%b want 3/1/0", bus.fifo_count, bus.busy, bus.out_valid); end
    reset = 1'b1;
    step();
    vectors++; if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.fpu_restart_n !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL midop_reset got valid=%b count=%0d restart_n=%b busy=%b want 0/0/0/0",
                              bus.out_valid, bus.fifo_count, bus.fpu_restart_n, bus.busy); end
    reset = 1'b0;
    repeat (40) step();
    vectors++; if (got_q.size() !== 0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL midop_discard got results=%0d busy=%b want 0/0", got_q.size(), bus.busy); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op_a   = '0;
    bus.in_op_b   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_backpressure();
    test_status_capture();
    test_reset_midop();
    vectors++; if (pulse_err !== 0) begin miscompares++; $display("FAIL restart_width got %0d long pulses want 0", pulse_err); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
